// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and control-bit clearing on bubbles.
module pipe_stage_hs #(
  parameter int unsigned DATA_W = 69,
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam bit USE_SKID = (SKID != 0);

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_ready_q;

  logic              out_valid_n;
  logic [CTRL_W-1:0] out_ctrl_n;
  logic [DATA_W-1:0] out_data_n;
  logic              skid_valid_n;
  logic [CTRL_W-1:0] skid_ctrl_n;
  logic [DATA_W-1:0] skid_data_n;
  logic [1:0]        occupancy_n;
  logic              in_ready_n;

  logic in_fire_c;
  logic out_fire_c;
  logic main_free_c;

  // With the skid buffer, ready is a flop; without it, ready follows downstream.
  assign in_ready    = USE_SKID ? in_ready_q : (!out_valid || out_ready);
  assign in_fire_c   = in_valid && in_ready;
  assign out_fire_c  = out_valid && out_ready;
  assign main_free_c = !out_valid || out_fire_c;

  // Next-state for main and skid registers; flush overrides everything.
  always_comb begin
    out_valid_n  = out_valid;
    out_ctrl_n   = out_ctrl;
    out_data_n   = out_data;
    skid_valid_n = skid_valid;
    skid_ctrl_n  = skid_ctrl;
    skid_data_n  = skid_data;

    if (flush) begin
      out_valid_n  = 1'b0;
      out_ctrl_n   = '0;
      skid_valid_n = 1'b0;
      skid_ctrl_n  = '0;
    end else begin
      if (main_free_c) begin
        if (skid_valid) begin
          out_valid_n  = 1'b1;
          out_ctrl_n   = skid_ctrl;
          out_data_n   = skid_data;
          skid_valid_n = 1'b0;
          skid_ctrl_n  = '0;
        end else if (in_fire_c) begin
          out_valid_n = 1'b1;
          out_ctrl_n  = in_ctrl;
          out_data_n  = in_data;
        end else begin
          out_valid_n = 1'b0;
          out_ctrl_n  = '0;
        end
      end
      // Main is stalled: park the accepted entry behind it.
      if (USE_SKID && in_fire_c && out_valid && !out_ready) begin
        skid_valid_n = 1'b1;
        skid_ctrl_n  = in_ctrl;
        skid_data_n  = in_data;
      end
    end

    occupancy_n = 2'({1'b0, out_valid_n}) + 2'({1'b0, skid_valid_n});
    in_ready_n  = !skid_valid_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      occupancy  <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      out_valid  <= out_valid_n;
      out_ctrl   <= out_ctrl_n;
      out_data   <= out_data_n;
      skid_valid <= skid_valid_n;
      skid_ctrl  <= skid_ctrl_n;
      skid_data  <= skid_data_n;
      occupancy  <= occupancy_n;
      in_ready_q <= in_ready_n;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: one SKID=1 instance and one SKID=0 instance.
module tb_pipe_stage_hs;

  localparam int unsigned DATA_W = 69;
  localparam int unsigned CTRL_W = 4;

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  logic              flush0;
  logic              in_valid0;
  logic              in_ready0;
  logic [CTRL_W-1:0] in_ctrl0;
  logic [DATA_W-1:0] in_data0;
  logic              out_valid0;
  logic              out_ready0;
  logic [CTRL_W-1:0] out_ctrl0;
  logic [DATA_W-1:0] out_data0;
  logic [1:0]        occupancy0;

  int n_checks;
  int n_fail;

  pipe_stage_hs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_hs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, '0, '0);
    flush0 = 1'b0; in_valid0 = 1'b0; in_ctrl0 = '0; in_data0 = '0; out_ready0 = 1'b1;

    // Reset held for 3 cycles
    repeat (3) tick();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_ctrl",  128'(out_ctrl),  128'd0);
    check("rst_out_data",  128'(out_data),  128'd0);
    check("rst_occupancy", 128'(occupancy), 128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd1);
    reset = 1'b0;

    // Back-to-back stream 1..5
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'b1010, DATA_W'(i));
      if (i == 1) begin
        #1;
        check("stream_pre_valid", 128'(out_valid), 128'd0);
      end
      tick();
      check("stream_valid", 128'(out_valid), 128'd1);
      check("stream_data",  128'(out_data),  128'(i));
      check("stream_ctrl",  128'(out_ctrl),  128'(4'b1010));
      check("stream_occ",   128'(occupancy), 128'd1);
      check("stream_ready", 128'(in_ready),  128'd1);
    end
    drive(1'b0, '0, '0);
    tick();
    check("drain_valid", 128'(out_valid), 128'd0);
    check("drain_ctrl",  128'(out_ctrl),  128'd0);
    check("drain_occ",   128'(occupancy), 128'd0);

    // Single entry then bubble
    drive(1'b1, 4'b0001, DATA_W'(77));
    tick();
    check("bub_valid1", 128'(out_valid), 128'd1);
    check("bub_ctrl1",  128'(out_ctrl),  128'(4'b0001));
    drive(1'b0, '0, '0);
    tick();
    check("bub_valid0", 128'(out_valid), 128'd0);
    check("bub_ctrl0",  128'(out_ctrl),  128'd0);
    check("bub_data",   128'(out_data),  128'd77);

    // Backpressure into the skid register
    drive(1'b1, 4'b1010, DATA_W'(10));
    tick();
    check("bp_data10", 128'(out_data), 128'd10);
    out_ready = 1'b0;
    drive(1'b1, 4'b1010, DATA_W'(11));
    tick();
    check("bp_occ2",    128'(occupancy), 128'd2);
    check("bp_ready0",  128'(in_ready),  128'd0);
    check("bp_hold10",  128'(out_data),  128'd10);
    drive(1'b1, 4'b1010, DATA_W'(12));
    tick();
    check("bp_still2",  128'(occupancy), 128'd2);
    check("bp_still10", 128'(out_data),  128'd10);
    check("bp_ready0b", 128'(in_ready),  128'd0);
    out_ready = 1'b1;
    tick();
    check("bp_data11",  128'(out_data),  128'd11);
    check("bp_occ1",    128'(occupancy), 128'd1);
    check("bp_ready1",  128'(in_ready),  128'd1);
    tick();
    check("bp_data12",  128'(out_data),  128'd12);
    check("bp_valid12", 128'(out_valid), 128'd1);
    drive(1'b0, '0, '0);
    tick();
    check("bp_empty",   128'(out_valid), 128'd0);

    // Flush with both entries held
    out_ready = 1'b0;
    drive(1'b1, 4'b1111, DATA_W'(20));
    tick();
    drive(1'b1, 4'b1111, DATA_W'(21));
    tick();
    check("fl_occ2", 128'(occupancy), 128'd2);
    drive(1'b1, 4'b1111, DATA_W'(22));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", 128'(out_valid), 128'd0);
    check("fl_ctrl",  128'(out_ctrl),  128'd0);
    check("fl_occ",   128'(occupancy), 128'd0);
    check("fl_ready", 128'(in_ready),  128'd1);
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    tick();
    check("fl_no22",  128'(out_valid), 128'd0);
    // Flush discards an input that fires in the same cycle
    drive(1'b1, 4'b1111, DATA_W'(23));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("fl_drop23", 128'(out_valid), 128'd0);
    check("fl_occ0b",  128'(occupancy), 128'd0);

    // SKID=0 instance: combinational ready and replace-on-fire
    in_valid0 = 1'b1; in_ctrl0 = 4'b0011; in_data0 = DATA_W'(40); out_ready0 = 1'b0;
    tick();
    check("s0_valid40", 128'(out_valid0), 128'd1);
    check("s0_data40",  128'(out_data0),  128'd40);
    in_data0 = DATA_W'(41);
    #1;
    check("s0_ready0",  128'(in_ready0),  128'd0);
    out_ready0 = 1'b1;
    #1;
    check("s0_ready1",  128'(in_ready0),  128'd1);
    tick();
    check("s0_data41",  128'(out_data0),  128'd41);
    check("s0_occ1",    128'(occupancy0), 128'd1);
    in_valid0 = 1'b0;
    tick();
    check("s0_bubble",  128'(out_valid0), 128'd0);
    check("s0_ctrl0",   128'(out_ctrl0),  128'd0);

    // Asynchronous reset with both entries held
    out_ready = 1'b0;
    drive(1'b1, 4'b0110, DATA_W'(30));
    tick();
    drive(1'b1, 4'b0110, DATA_W'(31));
    tick();
    drive(1'b0, '0, '0);
    check("ar_occ2", 128'(occupancy), 128'd2);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 128'(out_valid), 128'd0);
    check("ar_ctrl",  128'(out_ctrl),  128'd0);
    check("ar_data",  128'(out_data),  128'd0);
    check("ar_occ",   128'(occupancy), 128'd0);
    check("ar_ready", 128'(in_ready),  128'd1);
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline stage register with valid/ready handshake. It is the next generation of the fixed-field, enable-stalled inter-stage registers between EX, MEM and WB. Payload width and control width are generic, and an optional 2-entry skid buffer cuts the combinational ready path. It adds synchronous flush with bubble insertion, and guarantees that control bits are zero whenever the stage holds no valid instruction.

## Interface
Parameters:
- DATA_W, 69: payload width (datapath fields such as alu_result, rs2_data, rd); not cleared on bubble
- CTRL_W, 4: control width (reg_write, mem_to_reg, mem_read, mem_write …); forced to 0 on bubble
- SKID, 1: 1 = registered in_ready with 2-entry skid buffer; 0 = single register with combinational in_ready

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  reset, asynchronous, active-high; clock clk
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  upstream control bits
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  main register holds a valid entry
- out_ready  in  1  downstream accepts this cycle
- out_ctrl  out  CTRL_W  main register control; 0 when out_valid=0
- out_data  out  DATA_W  main register payload
- occupancy  out  2  entries held: 0, 1, 2 (2 only when SKID=1)

## Operation
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: a main register (out_valid, out_ctrl, out_data). When SKID=1, there is also a skid register (skid_valid, skid_ctrl, skid_data).
- in_ready:
  - SKID=1: in_ready = !skid_valid, a pure register output.
  - SKID=0: in_ready = !out_valid | out_ready.
- Main register update, when not in flush:
  - If !out_valid or out_fire:
    - skid_valid: load from skid; skid_valid <= 0.
    - Otherwise, if in_fire: load from input.
    - Otherwise: out_valid <= 0 and out_ctrl <= 0. out_data holds its value.
  - Otherwise: hold.
- Skid register update (SKID=1): in_fire while out_valid & !out_ready → capture input; skid_valid <= 1.
- Ordering: entries leave in arrival order. No entry is duplicated or dropped except by flush.
- flush: next edge clears out_valid, skid_valid, out_ctrl and skid_ctrl. A same-cycle in_fire is discarded. flush overrides every other update. Data fields hold their values.
- occupancy = out_valid + skid_valid.
- Reset values:
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0
  - skid state cleared, so in_ready=1
- Reset mid-operation drops all entries immediately (asynchronous).

## Timing
- Latency: input captured at edge N appears on out_* after edge N, when the stage is empty or draining.
- Throughput: 1 entry/cycle with out_ready held high, for both SKID values.
- SKID=1: when out_ready drops, one extra entry is absorbed into skid. in_ready falls at the next edge, never combinationally.
- After out_ready rises with skid full: skid moves to main at that edge and in_ready=1 in the following cycle.
- Simultaneous in_fire and out_fire with skid empty: main reloads from input, with no bubble.
- Handshake rule: upstream may not change in_ctrl/in_data while in_valid=1 and in_ready=0. The stage never depends on in_* when in_valid=0.

## Test plan
- Reset then stream (SKID=1): reset high 3 cycles with in_valid=0; then 5 back-to-back entries data=1..5, ctrl=4'b1010, out_ready=1. Required: out_valid rises 1 cycle after first in_fire, out_data=1..5 on consecutive cycles, occupancy ≤1.
- Backpressure/skid: stream data=10,11,12, drop out_ready after 10 is presented. Required: 11 held in skid, occupancy=2, in_ready=0 next cycle, 12 not accepted. After out_ready=1: outputs 10,11,12 in order, in_ready back to 1.
- Flush: occupancy=2 with ctrl=4'b1111 and in_valid=1; assert flush for 1 cycle. Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, and the flushed-cycle input never appears.
- Bubble control clearing: single entry ctrl=4'b0001 consumed with no follow-up. Required: next cycle out_valid=0, out_ctrl=0, out_data keeps its last value.
- SKID=0 build: out_valid=1, out_ready=0. Required: in_ready=0 combinationally. Setting out_ready=1 the same cycle → in_ready=1 and the new entry replaces the old at the edge.
- Async reset mid-stream: assert reset between edges while occupancy=2. Required: out_valid, out_ctrl, out_data and occupancy go to 0 without waiting for a clock edge.
